// File: rtl/mlp_layer_sequencer_if.sv
// Control and BRAM-port bundle between a host and the MLP layer sequencer.
// The host owns the start/configuration signals; the sequencer owns everything else.
interface mlp_layer_sequencer_if #(
  parameter int BRAM_WADDR = 11
);
  logic                  pi_start;
  logic [BRAM_WADDR-1:0] pi_num_inputs;
  logic [BRAM_WADDR-1:0] pi_num_neurons;
  logic [BRAM_WADDR-1:0] pi_base_inp;
  logic [BRAM_WADDR-1:0] pi_base_wei;
  logic [BRAM_WADDR-1:0] pi_base_bia;
  logic [BRAM_WADDR-1:0] pi_base_reg;

  logic                  po_busy;
  logic                  po_done;
  logic                  po_valid;
  logic                  po_clc_accumulator;
  logic                  po_accumulation_done;
  logic                  po_ena_inp;
  logic                  po_enb_inp;
  logic                  po_ena_wei;
  logic                  po_enb_wei;
  logic                  po_ena_bia;
  logic                  po_enb_bia;
  logic [BRAM_WADDR-1:0] po_addra_inp;
  logic [BRAM_WADDR-1:0] po_addrb_inp;
  logic [BRAM_WADDR-1:0] po_addra_wei;
  logic [BRAM_WADDR-1:0] po_addrb_wei;
  logic [BRAM_WADDR-1:0] po_addra_bia;
  logic [BRAM_WADDR-1:0] po_addrb_bia;
  logic                  po_ena_reg;
  logic                  po_enb_reg;
  logic                  po_wea_reg;
  logic                  po_web_reg;
  logic [BRAM_WADDR-1:0] po_addra_reg;
  logic [BRAM_WADDR-1:0] po_addrb_reg;

  modport master (
    output pi_start, pi_num_inputs, pi_num_neurons,
           pi_base_inp, pi_base_wei, pi_base_bia, pi_base_reg,
    input  po_busy, po_done, po_valid, po_clc_accumulator, po_accumulation_done,
           po_ena_inp, po_enb_inp, po_ena_wei, po_enb_wei, po_ena_bia, po_enb_bia,
           po_addra_inp, po_addrb_inp, po_addra_wei, po_addrb_wei,
           po_addra_bia, po_addrb_bia,
           po_ena_reg, po_enb_reg, po_wea_reg, po_web_reg, po_addra_reg, po_addrb_reg
  );

  modport slave (
    input  pi_start, pi_num_inputs, pi_num_neurons,
           pi_base_inp, pi_base_wei, pi_base_bia, pi_base_reg,
    output po_busy, po_done, po_valid, po_clc_accumulator, po_accumulation_done,
           po_ena_inp, po_enb_inp, po_ena_wei, po_enb_wei, po_ena_bia, po_enb_bia,
           po_addra_inp, po_addrb_inp, po_addra_wei, po_addrb_wei,
           po_addra_bia, po_addrb_bia,
           po_ena_reg, po_enb_reg, po_wea_reg, po_web_reg, po_addra_reg, po_addrb_reg
  );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Sequences one dense MLP layer two neurons at a time (port A even, port B odd),
// generating BRAM reads for inputs/weights/biases and output-register writes.
module mlp_layer_sequencer #(
  parameter int BRAM_WADDR = 11,
  parameter int NEURON_LAT = 3
) (
  input logic                  pi_clk,
  input logic                  pi_rst,
  mlp_layer_sequencer_if.slave bus
);
  localparam int W = BRAM_WADDR;
  localparam logic [W-1:0] ONE       = W'(1);
  localparam logic [W:0]   ONE_X     = (W+1)'(1);
  localparam logic [W:0]   TWO_X     = (W+1)'(2);
  localparam logic [W-1:0] WAIT_LAST = W'((NEURON_LAT > 1) ? NEURON_LAT - 2 : 0);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, FLUSH, FIRE, WAIT, WRITE, FINISH} state_t;

  typedef struct packed {
    logic         busy;
    logic         done;
    logic         valid;
    logic         clc;
    logic         acc_done;
    logic         ena_inp;
    logic         enb_inp;
    logic         ena_wei;
    logic         enb_wei;
    logic         ena_bia;
    logic         enb_bia;
    logic         ena_reg;
    logic         enb_reg;
    logic         wea_reg;
    logic         web_reg;
    logic [W-1:0] addra_inp;
    logic [W-1:0] addrb_inp;
    logic [W-1:0] addra_wei;
    logic [W-1:0] addrb_wei;
    logic [W-1:0] addra_bia;
    logic [W-1:0] addrb_bia;
    logic [W-1:0] addra_reg;
    logic [W-1:0] addrb_reg;
  } out_t;

  state_t       state, state_d;
  logic [W-1:0] cnt, cnt_d;
  logic [W-1:0] pair, pair_d;
  logic [W-1:0] row, row_d;
  logic [W-1:0] num_inp, num_neu, base_inp, base_wei, base_bia, base_reg;
  logic [W-1:0] n_c, m_c, bi_c, bb_c, br_c;
  out_t         out_q, out_d;

  // In IDLE the configuration is taken straight from the bus so the first
  // registered cycle after start already carries correct addresses.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pair_d  = pair;
    row_d   = row;
    out_d   = '0;
    if (state == IDLE) begin
      n_c  = bus.pi_num_inputs;
      m_c  = bus.pi_num_neurons;
      bi_c = bus.pi_base_inp;
      bb_c = bus.pi_base_bia;
      br_c = bus.pi_base_reg;
    end else begin
      n_c  = num_inp;
      m_c  = num_neu;
      bi_c = base_inp;
      bb_c = base_bia;
      br_c = base_reg;
    end

    case (state)
      IDLE: begin
        if (bus.pi_start) begin
          cnt_d   = '0;
          pair_d  = '0;
          row_d   = bus.pi_base_wei;
          state_d = (bus.pi_num_inputs == '0 || bus.pi_num_neurons == '0) ? FINISH : CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (cnt == n_c - ONE) begin
          cnt_d   = '0;
          state_d = FLUSH;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      FLUSH: state_d = FIRE;
      FIRE: begin
        cnt_d   = '0;
        state_d = (NEURON_LAT > 1) ? WAIT : WRITE;
      end
      WAIT: begin
        if (cnt == WAIT_LAST) state_d = WRITE;
        else                  cnt_d   = cnt + ONE;
      end
      WRITE: begin
        if (({1'b0, pair} + TWO_X) >= {1'b0, m_c}) begin
          state_d = FINISH;
        end else begin
          pair_d  = pair + W'(2);
          row_d   = row + {n_c[W-2:0], 1'b0};
          state_d = CLEAR;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the state being entered, then registered.
    out_d.valid = out_q.ena_inp;
    out_d.busy  = (state_d != IDLE) && (state_d != FINISH);
    case (state_d)
      CLEAR: begin
        out_d.clc       = 1'b1;
        out_d.ena_bia   = 1'b1;
        out_d.enb_bia   = 1'b1;
        out_d.addra_bia = bb_c + pair_d;
        out_d.addrb_bia = bb_c + pair_d + ONE;
      end
      ACCUM: begin
        out_d.ena_inp   = 1'b1;
        out_d.enb_inp   = 1'b1;
        out_d.ena_wei   = 1'b1;
        out_d.enb_wei   = 1'b1;
        out_d.addra_inp = bi_c + cnt_d;
        out_d.addrb_inp = bi_c + cnt_d;
        out_d.addra_wei = row_d + cnt_d;
        out_d.addrb_wei = row_d + n_c + cnt_d;
        out_d.addra_bia = bb_c + pair_d;
        out_d.addrb_bia = bb_c + pair_d + ONE;
      end
      FIRE: out_d.acc_done = 1'b1;
      WRITE: begin
        out_d.ena_reg   = 1'b1;
        out_d.wea_reg   = 1'b1;
        out_d.enb_reg   = (({1'b0, pair_d} + ONE_X) < {1'b0, m_c});
        out_d.web_reg   = (({1'b0, pair_d} + ONE_X) < {1'b0, m_c});
        out_d.addra_reg = br_c + pair_d;
        out_d.addrb_reg = br_c + pair_d + ONE;
      end
      FINISH: out_d.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge pi_clk) begin
    if (!pi_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pair     <= '0;
      row      <= '0;
      num_inp  <= '0;
      num_neu  <= '0;
      base_inp <= '0;
      base_wei <= '0;
      base_bia <= '0;
      base_reg <= '0;
      out_q    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      pair  <= pair_d;
      row   <= row_d;
      out_q <= out_d;
      if (state == IDLE && bus.pi_start) begin
        num_inp  <= bus.pi_num_inputs;
        num_neu  <= bus.pi_num_neurons;
        base_inp <= bus.pi_base_inp;
        base_wei <= bus.pi_base_wei;
        base_bia <= bus.pi_base_bia;
        base_reg <= bus.pi_base_reg;
      end
    end
  end

  assign bus.po_busy              = out_q.busy;
  assign bus.po_done              = out_q.done;
  assign bus.po_valid             = out_q.valid;
  assign bus.po_clc_accumulator   = out_q.clc;
  assign bus.po_accumulation_done = out_q.acc_done;
  assign bus.po_ena_inp           = out_q.ena_inp;
  assign bus.po_enb_inp           = out_q.enb_inp;
  assign bus.po_ena_wei           = out_q.ena_wei;
  assign bus.po_enb_wei           = out_q.enb_wei;
  assign bus.po_ena_bia           = out_q.ena_bia;
  assign bus.po_enb_bia           = out_q.enb_bia;
  assign bus.po_addra_inp         = out_q.addra_inp;
  assign bus.po_addrb_inp         = out_q.addrb_inp;
  assign bus.po_addra_wei         = out_q.addra_wei;
  assign bus.po_addrb_wei         = out_q.addrb_wei;
  assign bus.po_addra_bia         = out_q.addra_bia;
  assign bus.po_addrb_bia         = out_q.addrb_bia;
  assign bus.po_ena_reg           = out_q.ena_reg;
  assign bus.po_enb_reg           = out_q.enb_reg;
  assign bus.po_wea_reg           = out_q.wea_reg;
  assign bus.po_web_reg           = out_q.web_reg;
  assign bus.po_addra_reg         = out_q.addra_reg;
  assign bus.po_addrb_reg         = out_q.addrb_reg;
endmodule

// File: doc/mlp_layer_sequencer.md
MLP_LAYER_SEQUENCER -- requirements
Module: mlp_layer_sequencer

Interface
REQ-001 SHALL have parameter BRAM_WADDR, 11, address width of every data-path BRAM port.
REQ-002 SHALL have parameter NEURON_LAT, 3, cycles from po_accumulation_done high to sigmoid output valid at the output-register BRAM data inputs (1..15).
REQ-003 SHALL have ports:
- pi_clk  in  1  single clock, all logic rising-edge.
- pi_rst  in  1  synchronous, active-low reset.
- pi_start  in  1  one-cycle pulse, starts one layer.
- pi_num_inputs  in  BRAM_WADDR  inputs per neuron (N).
- pi_num_neurons  in  BRAM_WADDR  neurons in layer (M).
- pi_base_inp, pi_base_wei, pi_base_bia, pi_base_reg  in  BRAM_WADDR each  region base addresses.
- po_busy  out  1  high from the cycle after accepted start until po_done.
- po_done  out  1  one-cycle pulse, layer finished.
- po_valid, po_clc_accumulator, po_accumulation_done  out  1 each  neuron control.
- po_ena_inp, po_enb_inp, po_ena_wei, po_enb_wei, po_ena_bia, po_enb_bia  out  1 each  read enables.
- po_addra_inp, po_addrb_inp, po_addra_wei, po_addrb_wei, po_addra_bia, po_addrb_bia  out  BRAM_WADDR each  read addresses.
- po_ena_reg, po_enb_reg, po_wea_reg, po_web_reg  out  1 each  output-register write strobes.
- po_addra_reg, po_addrb_reg  out  BRAM_WADDR each  output-register addresses.
REQ-004 SHALL tie no write enable for inp/wei/bia; the block only reads them.

Function
REQ-005 Neurons SHALL be processed in pairs k = 0..ceil(M/2)-1: port A computes neuron 2k, port B neuron 2k+1.
REQ-006 States SHALL be IDLE, CLEAR, ACCUM, FLUSH, FIRE, WAIT, WRITE, FINISH.
REQ-007 IDLE: pi_start=1 SHALL latch all pi_num_*/pi_base_* and go to CLEAR; if N=0 or M=0, go directly to FINISH with no BRAM access.
REQ-008 CLEAR (1 cycle): po_clc_accumulator=1; po_ena_bia=po_enb_bia=1 at pi_base_bia+2k and +2k+1; next ACCUM.
REQ-009 ACCUM (N cycles, i=0..N-1): inp ports A and B both at pi_base_inp+i; wei A at pi_base_wei+2k*N+i, wei B at pi_base_wei+(2k+1)*N+i; all four enables=1; bias address held.
REQ-010 po_valid SHALL be the ACCUM enable delayed one cycle (BRAM read latency 1), giving exactly N valid cycles per pair.
REQ-011 FLUSH (1 cycle): enables 0, carries the last po_valid; next FIRE.
REQ-012 FIRE (1 cycle): po_accumulation_done=1; next WAIT.
REQ-013 WAIT SHALL last NEURON_LAT-1 cycles (zero when NEURON_LAT=1), then WRITE.
REQ-014 WRITE (1 cycle): po_ena_reg=po_wea_reg=1 at pi_base_reg+2k; po_enb_reg=po_web_reg=1 at pi_base_reg+2k+1 only if 2k+1<M; then CLEAR for k+1, or FINISH after last pair.
REQ-015 FINISH (1 cycle): po_done=1, po_busy=0 same cycle; next IDLE.
REQ-016 All address arithmetic SHALL be modulo 2^BRAM_WADDR (wrap, no error flag); weight row pointer advanced by 2N per pair, no multiplier required.
REQ-017 For odd M, final pair port B reads (any data) but SHALL NOT write.
REQ-018 pi_start while not IDLE SHALL be ignored; input changes after latch SHALL have no effect.
REQ-019 Cycles per pair SHALL be N+NEURON_LAT+3; layer total = 1 + ceil(M/2)*(N+NEURON_LAT+3) + 1 from start to done.
REQ-020 All outputs SHALL be registered and driven 0 in any state not listed as asserting them.

Reset
REQ-021 pi_rst=0 at a rising edge SHALL force IDLE and all outputs, counters and latched values to 0, including mid-layer; no write strobe SHALL appear in the cycle after reset.
REQ-022 After release, the first accepted start SHALL behave as from power-up.

Verification
REQ-023 N=3, M=2, NEURON_LAT=3, bases 0/100/200/300: wei A 100,101,102, B 103,104,105; 3 po_valid; done at cycle 11 after start; reg writes 300/301.
REQ-024 M=3, N=2: pair 1 writes only po_addra_reg=base_reg+2; po_web_reg stays 0.
REQ-025 N=0 or M=0: po_done one cycle after start, no enable ever high.
REQ-026 pi_base_wei=2046, N=2, M=2: addresses 2046,2047,0,1 (wrap).
REQ-027 Reset low during ACCUM of pair 0: all outputs 0 next cycle; pi_start reissued produces a full, correct layer.
REQ-028 pi_start pulsed while busy: no restart, done count stays one.
